// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer and the
// hazard comparators that sit next to it.
package pipeline_ctrl_pkg;

  localparam int REG_IDX_W = 5;
  localparam logic [REG_IDX_W-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_e;

  // Every pipeline-register control driven by the sequencer, in one bundle.
  typedef struct packed {
    logic en_pc;
    logic en_if_id;
    logic en_id_ex;
    logic en_ex_mem;
    logic en_mem_wb;
    logic flush_if_id;
    logic bubble_id_ex;
    logic flush_ex_mem;
    logic pc_sel_branch;
  } ctrl_out_t;

  localparam ctrl_out_t CTRL_FREEZE = '0;

  localparam ctrl_out_t CTRL_FLOW = '{
    en_pc: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1, en_ex_mem: 1'b1, en_mem_wb: 1'b1,
    flush_if_id: 1'b0, bubble_id_ex: 1'b0, flush_ex_mem: 1'b0, pc_sel_branch: 1'b0
  };

  localparam ctrl_out_t CTRL_BRANCH = '{
    en_pc: 1'b1, en_if_id: 1'b1, en_id_ex: 1'b1, en_ex_mem: 1'b1, en_mem_wb: 1'b1,
    flush_if_id: 1'b1, bubble_id_ex: 1'b1, flush_ex_mem: 1'b1, pc_sel_branch: 1'b1
  };

  localparam ctrl_out_t CTRL_LOAD_USE = '{
    en_pc: 1'b0, en_if_id: 1'b0, en_id_ex: 1'b1, en_ex_mem: 1'b1, en_mem_wb: 1'b1,
    flush_if_id: 1'b0, bubble_id_ex: 1'b1, flush_ex_mem: 1'b0, pc_sel_branch: 1'b0
  };

  // Controls for a cycle in which the memory stage is not blocking progress.
  // A taken branch squashes the instruction in ID, so load-use is moot then.
  function automatic ctrl_out_t flow_rules(input logic branch_taken,
                                           input logic load_use);
    if (branch_taken) begin
      return CTRL_BRANCH;
    end else if (load_use) begin
      return CTRL_LOAD_USE;
    end
    return CTRL_FLOW;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a load in ID/EX whose destination is read
// by the instruction in IF/ID. x0 never creates a dependency.
module load_use_detect
  import pipeline_ctrl_pkg::*;
(
  input  logic                 ex_memread_i,
  input  logic [REG_IDX_W-1:0] ex_rd_i,
  input  logic [REG_IDX_W-1:0] id_rs1_i,
  input  logic [REG_IDX_W-1:0] id_rs2_i,
  input  logic                 id_uses_rs2_i,
  output logic                 load_use_o
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match  = (ex_rd_i == id_rs1_i);
  assign rs2_match  = id_uses_rs2_i && (ex_rd_i == id_rs2_i);
  assign load_use_o = ex_memread_i && (ex_rd_i != REG_X0) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: memory wait states,
// taken branches resolved in MEM, load-use stalls, timeout halt and statistics.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_uses_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_memread,
  input  logic                 mem_branch_taken,
  input  logic                 dmem_req,
  input  logic                 dmem_ready,
  output logic                 en_pc,
  output logic                 en_if_id,
  output logic                 en_id_ex,
  output logic                 en_ex_mem,
  output logic                 en_mem_wb,
  output logic                 flush_if_id,
  output logic                 bubble_id_ex,
  output logic                 flush_ex_mem,
  output logic                 pc_sel_branch,
  output logic                 err_timeout,
  output logic [1:0]           ctrl_state,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam int WAIT_W = ($clog2(MAX_WAIT + 1) > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0]  CNT_MAX    = {CNT_W{1'b1}};

  ctrl_state_e       state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_timeout_q, err_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic      load_use;
  ctrl_out_t ctrl;
  ctrl_out_t ctrl_out;

  load_use_detect u_load_use_detect (
    .ex_memread_i  (ex_memread),
    .ex_rd_i       (ex_rd),
    .id_rs1_i      (id_rs1),
    .id_rs2_i      (id_rs2),
    .id_uses_rs2_i (id_uses_rs2),
    .load_use_o    (load_use)
  );

  always_comb begin
    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    err_timeout_d = err_timeout_q;
    ctrl          = CTRL_FREEZE;

    case (state_q)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end else begin
          ctrl = flow_rules(mem_branch_taken, load_use);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          ctrl       = flow_rules(mem_branch_taken, load_use);
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LIMIT) begin
          state_d       = HALT;
          err_timeout_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Reset also blanks the controls combinationally, before any clock edge.
  assign ctrl_out = arst ? CTRL_FREEZE : ctrl;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!ctrl_out.en_pc && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (ctrl_out.pc_sel_branch && (flush_cnt_q != CNT_MAX)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them sample
  // the pre-edge values of one another.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      err_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      err_timeout_q <= err_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  assign en_pc         = ctrl_out.en_pc;
  assign en_if_id      = ctrl_out.en_if_id;
  assign en_id_ex      = ctrl_out.en_id_ex;
  assign en_ex_mem     = ctrl_out.en_ex_mem;
  assign en_mem_wb     = ctrl_out.en_mem_wb;
  assign flush_if_id   = ctrl_out.flush_if_id;
  assign bubble_id_ex  = ctrl_out.bubble_id_ex;
  assign flush_ex_mem  = ctrl_out.flush_ex_mem;
  assign pc_sel_branch = ctrl_out.pc_sel_branch;

  assign err_timeout = err_timeout_q;
  assign ctrl_state  = state_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: load-use, branch, memory wait,
// timeout, async reset and counter saturation (second instance with CNT_W=4).
module tb_pipeline_hazard_ctrl;

  localparam logic [8:0] OUT_ZERO   = 9'b00000_000_0;
  localparam logic [8:0] OUT_FLOW   = 9'b11111_000_0;
  localparam logic [8:0] OUT_LOADU  = 9'b00111_010_0;
  localparam logic [8:0] OUT_BRANCH = 9'b11111_111_1;

  logic       clk = 1'b0;
  logic       arst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_memread, mem_branch_taken, dmem_req, dmem_ready;

  logic        en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb;
  logic        flush_if_id, bubble_id_ex, flush_ex_mem, pc_sel_branch, err_timeout;
  logic [1:0]  ctrl_state;
  logic [31:0] stall_cnt, flush_cnt;

  logic        s_en_pc, s_en_if_id, s_en_id_ex, s_en_ex_mem, s_en_mem_wb;
  logic        s_flush_if_id, s_bubble_id_ex, s_flush_ex_mem, s_pc_sel_branch, s_err_timeout;
  logic [1:0]  s_ctrl_state;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  logic [8:0] obs;
  assign obs = {en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb,
                flush_if_id, bubble_id_ex, flush_ex_mem, pc_sel_branch};

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MAX_WAIT(15), .CNT_W(32)) dut (
    .clk(clk), .arst(arst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_branch_taken(mem_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .en_pc(en_pc), .en_if_id(en_if_id), .en_id_ex(en_id_ex), .en_ex_mem(en_ex_mem),
    .en_mem_wb(en_mem_wb), .flush_if_id(flush_if_id), .bubble_id_ex(bubble_id_ex),
    .flush_ex_mem(flush_ex_mem), .pc_sel_branch(pc_sel_branch), .err_timeout(err_timeout),
    .ctrl_state(ctrl_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.MAX_WAIT(15), .CNT_W(4)) dut_sat (
    .clk(clk), .arst(arst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .mem_branch_taken(mem_branch_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .en_pc(s_en_pc), .en_if_id(s_en_if_id), .en_id_ex(s_en_id_ex), .en_ex_mem(s_en_ex_mem),
    .en_mem_wb(s_en_mem_wb), .flush_if_id(s_flush_if_id), .bubble_id_ex(s_bubble_id_ex),
    .flush_ex_mem(s_flush_ex_mem), .pc_sel_branch(s_pc_sel_branch),
    .err_timeout(s_err_timeout), .ctrl_state(s_ctrl_state),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0; id_uses_rs2 = 1'b0;
    ex_memread = 1'b0; mem_branch_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    arst = 1'b1;
    idle_inputs();
    tick();
    arst = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    idle_inputs();
    #1;
    n_cmp++; if (obs !== OUT_ZERO) begin n_mis++; $display("FAIL reset_outputs: got %b expected %b", obs, OUT_ZERO); end
    n_cmp++; if (ctrl_state !== 2'd0) begin n_mis++; $display("FAIL reset_state: got %0d expected 0", ctrl_state); end
    n_cmp++; if ({err_timeout, stall_cnt, flush_cnt} !== 65'd0) begin n_mis++; $display("FAIL reset_regs: got err=%b stall=%0d flush=%0d expected all 0", err_timeout, stall_cnt, flush_cnt); end
    tick();
    arst = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs !== OUT_FLOW) begin n_mis++; $display("FAIL post_reset_flow: got %b expected %b", obs, OUT_FLOW); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5;
    @(negedge clk);
    n_cmp++; if (obs !== OUT_LOADU) begin n_mis++; $display("FAIL load_use_rs1: got %b expected %b", obs, OUT_LOADU); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (obs !== OUT_FLOW) begin n_mis++; $display("FAIL load_use_release: got %b expected %b", obs, OUT_FLOW); end
    n_cmp++; if (stall_cnt !== 32'd1) begin n_mis++; $display("FAIL load_use_stall_cnt: got %0d expected 1", stall_cnt); end
    tick();
    ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0;
    @(negedge clk);
    n_cmp++; if (obs !== OUT_FLOW) begin n_mis++; $display("FAIL load_use_x0: got %b expected %b", obs, OUT_FLOW); end
    tick();
    ex_rd = 5'd7; id_rs1 = 5'd3; id_rs2 = 5'd7; id_uses_rs2 = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs !== OUT_FLOW) begin n_mis++; $display("FAIL load_use_rs2_unused: got %b expected %b", obs, OUT_FLOW); end
    tick();
    id_uses_rs2 = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs !== OUT_LOADU) begin n_mis++; $display("FAIL load_use_rs2: got %b expected %b", obs, OUT_LOADU); end
    tick();
    ex_memread = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs !== OUT_FLOW) begin n_mis++; $display("FAIL not_a_load: got %b expected %b", obs, OUT_FLOW); end
    n_cmp++; if (stall_cnt !== 32'd2) begin n_mis++; $display("FAIL load_use_stall_cnt2: got %0d expected 2", stall_cnt); end
    tick();
    idle_inputs();
  endtask

  task automatic test_branch();
    do_reset();
    mem_branch_taken = 1'b1; ex_memread = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9;
    @(negedge clk);
    n_cmp++; if (obs !== OUT_BRANCH) begin n_mis++; $display("FAIL branch_outputs: got %b expected %b", obs, OUT_BRANCH); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (flush_cnt !== 32'd1) begin n_mis++; $display("FAIL branch_flush_cnt: got %0d expected 1", flush_cnt); end
    n_cmp++; if (stall_cnt !== 32'd0) begin n_mis++; $display("FAIL branch_stall_cnt: got %0d expected 0", stall_cnt); end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_cmp++; if (obs !== OUT_ZERO) begin n_mis++; $display("FAIL wait_frozen c%0d: got %b expected %b", c, obs, OUT_ZERO); end
      n_cmp++; if (ctrl_state !== ((c == 1) ? 2'd0 : 2'd1)) begin n_mis++; $display("FAIL wait_state c%0d: got %0d expected %0d", c, ctrl_state, (c == 1) ? 0 : 1); end
      tick();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs !== OUT_FLOW) begin n_mis++; $display("FAIL wait_release: got %b expected %b", obs, OUT_FLOW); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if (ctrl_state !== 2'd0) begin n_mis++; $display("FAIL wait_back_to_run: got %0d expected 0", ctrl_state); end
    n_cmp++; if (stall_cnt !== 32'd4) begin n_mis++; $display("FAIL wait_stall_cnt: got %0d expected 4", stall_cnt); end
    tick();
  endtask

  task automatic test_wait_then_branch();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0; mem_branch_taken = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs !== OUT_ZERO) begin n_mis++; $display("FAIL wait_branch_held: got %b expected %b", obs, OUT_ZERO); end
    tick();
    dmem_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if (obs !== OUT_BRANCH) begin n_mis++; $display("FAIL wait_branch_release: got %b expected %b", obs, OUT_BRANCH); end
    tick();
    idle_inputs();
    @(negedge clk);
    n_cmp++; if ({stall_cnt, flush_cnt} !== {32'd1, 32'd1}) begin n_mis++; $display("FAIL wait_branch_cnts: got stall=%0d flush=%0d expected 1/1", stall_cnt, flush_cnt); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      n_cmp++; if (obs !== OUT_ZERO) begin n_mis++; $display("FAIL timeout_frozen c%0d: got %b expected %b", c, obs, OUT_ZERO); end
      if (c == 16) begin
        n_cmp++; if ({ctrl_state, err_timeout} !== {2'd1, 1'b0}) begin n_mis++; $display("FAIL timeout_last_wait: got state=%0d err=%b expected 1/0", ctrl_state, err_timeout); end
      end
      tick();
    end
    dmem_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if ({obs, ctrl_state, err_timeout} !== {OUT_ZERO, 2'd2, 1'b1}) begin n_mis++; $display("FAIL halt_hold c%0d: got out=%b state=%0d err=%b expected %b/2/1", c, obs, ctrl_state, err_timeout, OUT_ZERO); end
      tick();
    end
    @(negedge clk);
    n_cmp++; if (stall_cnt !== 32'd19) begin n_mis++; $display("FAIL halt_stall_cnt: got %0d expected 19", stall_cnt); end
    tick();
    #2 arst = 1'b1;
    #1;
    n_cmp++; if ({ctrl_state, err_timeout, stall_cnt, flush_cnt} !== 67'd0) begin n_mis++; $display("FAIL halt_reset: got state=%0d err=%b stall=%0d flush=%0d expected all 0", ctrl_state, err_timeout, stall_cnt, flush_cnt); end
    tick();
    arst = 1'b0;
    @(negedge clk);
    n_cmp++; if (obs !== OUT_FLOW) begin n_mis++; $display("FAIL halt_recover: got %b expected %b", obs, OUT_FLOW); end
    tick();
    idle_inputs();
  endtask

  task automatic test_async_reset_mid_wait();
    do_reset();
    dmem_req = 1'b1; dmem_ready = 1'b0;
    tick();
    tick();
    dmem_ready = 1'b1;
    #1;
    n_cmp++; if ({obs, ctrl_state} !== {OUT_FLOW, 2'd1}) begin n_mis++; $display("FAIL mid_wait_ready: got out=%b state=%0d expected %b/1", obs, ctrl_state, OUT_FLOW); end
    #1 arst = 1'b1;
    #1;
    n_cmp++; if ({obs, ctrl_state, stall_cnt} !== {OUT_ZERO, 2'd0, 32'd0}) begin n_mis++; $display("FAIL async_reset_immediate: got out=%b state=%0d stall=%0d expected %b/0/0", obs, ctrl_state, stall_cnt, OUT_ZERO); end
    tick();
    arst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    ex_memread = 1'b1; ex_rd = 5'd12; id_rs1 = 5'd12;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 15) begin
        n_cmp++; if (s_stall_cnt !== 4'd15) begin n_mis++; $display("FAIL sat_stall_at_15: got %0d expected 15", s_stall_cnt); end
      end
    end
    n_cmp++; if (s_stall_cnt !== 4'd15) begin n_mis++; $display("FAIL sat_stall_hold: got %0d expected 15", s_stall_cnt); end
    n_cmp++; if (stall_cnt !== 32'd20) begin n_mis++; $display("FAIL wide_stall_20: got %0d expected 20", stall_cnt); end
    idle_inputs();
    mem_branch_taken = 1'b1;
    for (int c = 1; c <= 18; c++) tick();
    n_cmp++; if (s_flush_cnt !== 4'd15) begin n_mis++; $display("FAIL sat_flush_hold: got %0d expected 15", s_flush_cnt); end
    n_cmp++; if (flush_cnt !== 32'd18) begin n_mis++; $display("FAIL wide_flush_18: got %0d expected 18", flush_cnt); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_wait_then_branch();
    test_timeout();
    test_async_reset_mid_wait();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. It drives the enable inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the bubble/flush controls that zero their contents. It handles three events: data-memory wait states, taken branches resolved in MEM, and load-use hazards. It also keeps saturating stall/flush statistics and halts the pipeline on a memory timeout.

## Interface
- MAX_WAIT, 15: longest tolerated dmem wait, in cycles, before halting.
- CNT_W, 32: width of the statistics counters.
- clk  in  1  core clock.
- arst  in  1  asynchronous reset, active-high.
- id_rs1  in  5  rs1 of the instruction in IF/ID.
- id_rs2  in  5  rs2 of the instruction in IF/ID.
- id_uses_rs2  in  1  IF/ID instruction reads rs2.
- ex_rd  in  5  destination register held in ID/EX.
- ex_memread  in  1  ID/EX instruction is a load.
- mem_branch_taken  in  1  EX/MEM membranch AND zero.
- dmem_req  in  1  MEM stage issues a load or store this cycle.
- dmem_ready  in  1  data memory completes the access this cycle.
- en_pc, en_if_id, en_id_ex, en_ex_mem, en_mem_wb  out  1 each  register enables.
- flush_if_id  out  1  load a NOP into IF/ID; effective only when en_if_id=1.
- bubble_id_ex  out  1  zero all ID/EX control fields; effective only when en_id_ex=1.
- flush_ex_mem  out  1  zero all EX/MEM control fields; effective only when en_ex_mem=1.
- pc_sel_branch  out  1  PC mux selects the EX/MEM branch target.
- err_timeout  out  1  sticky memory-timeout flag.
- ctrl_state  out  2  current FSM state.
- stall_cnt  out  CNT_W  cycles in which en_pc=0.
- flush_cnt  out  CNT_W  taken-branch flushes.

## Operation
- FSM states: RUN=0, MEM_WAIT=1, HALT=2. Encoding 3 is illegal and recovers to RUN.
- The load-use condition is: ex_memread AND ex_rd!=0 AND (ex_rd==id_rs1 OR (id_uses_rs2 AND ex_rd==id_rs2)).
- RUN evaluates the following rules in priority order:
  1. dmem_req AND NOT dmem_ready:
     - All enables=0; no flush.
     - Next state MEM_WAIT; wait_cnt<=1.
  2. mem_branch_taken:
     - All enables=1, pc_sel_branch=1.
     - flush_if_id=1, bubble_id_ex=1, flush_ex_mem=1.
     - flush_cnt++. Load-use is ignored because the instruction in ID is being squashed.
  3. Load-use:
     - en_pc=0, en_if_id=0.
     - en_id_ex=1 with bubble_id_ex=1.
     - en_ex_mem=1, en_mem_wb=1.
  4. Otherwise: all enables=1, all flush outputs=0.
- MEM_WAIT:
  - dmem_ready=1: apply RUN rules 2–4 this cycle; next state RUN.
  - Otherwise: all enables=0.
    - wait_cnt==MAX_WAIT: next state HALT, err_timeout<=1.
    - Else wait_cnt++.
- HALT: all enables=0 and all flush outputs=0 until arst.
- stall_cnt increments in every cycle with en_pc=0, including cycles spent in HALT.
- Both statistics counters saturate at all-ones.
- A taken branch coinciding with a dmem wait in RUN is not lost: EX/MEM is held, so the branch re-asserts when the wait completes.

## Timing
- All outputs are combinational (Mealy) from the current state and inputs, and are valid in the same cycle.
- Registered: state, wait_cnt, err_timeout, stall_cnt, flush_cnt.
- Reset (arst=1, asynchronous):
  - State RUN; wait_cnt, counters and err_timeout = 0.
  - All enables and flush outputs are forced to 0 while arst is high.
- First cycle after reset release: RUN rules apply.
- Load-use costs exactly 1 stall cycle. A taken branch costs 3 squashed slots and 0 stall cycles.
- A dmem access with ready arriving after N cycles (N≤MAX_WAIT) freezes the pipeline for exactly N cycles.
- Reset asserted in MEM_WAIT or HALT returns to RUN and clears err_timeout.

## Structure
- Shared package pipeline_ctrl_pkg holds:
  - The state enum (RUN/MEM_WAIT/HALT).
  - The register-index width (5).
  - The x0 constant.
- Sub-module load_use_detect: purely combinational comparator producing the load-use condition. This lets the same comparator be reused by the forwarding unit.
- The counters are inline in pipeline_hazard_ctrl.

## Test plan
- **Load-use:** ex_memread=1, ex_rd=5, id_rs1=5 for 1 cycle → en_pc=en_if_id=0, bubble_id_ex=1 for one cycle; stall_cnt=1. Repeat with ex_rd=0 → no stall.
- **Taken branch:** mem_branch_taken=1 with a simultaneous load-use → pc_sel_branch=1, all three flush outputs=1, en_pc=1; flush_cnt=1, stall_cnt=0.
- **Memory wait:** dmem_req=1, dmem_ready low for 4 cycles then high → enables 0 for 4 cycles; ctrl_state=1 for cycles 2–4, then 0; stall_cnt=4.
- **Timeout:** dmem_ready never asserted with MAX_WAIT=15 → ctrl_state=2 and err_timeout=1 after cycle 16. Enables stay 0 thereafter; arst pulse restores RUN and clears all counters.
- **Saturation:** CNT_W=4 with 20 load-use stalls → stall_cnt holds 15.
- **Async reset mid-wait:** assert arst between clock edges in MEM_WAIT → outputs go to 0 immediately, without waiting for a clock edge.
